iter_shifter: RTL and testbench

Parametrised multi-cycle shift unit for the execute stage. It replaces fixed-distance wiring shifters, such as the constant left-by-2 branch-offset shift, wherever the distance or direction is run-time data. Logical-left, logical-right, arithmetic-right and rotate-left operations advance by at most STEP bit positions per clock, trading latency for a small STEP-wide mux instead of a full barrel shifter. A start/busy/done handshake lets the pipeline stall control wait for the result.

---
 rtl/iter_shifter_if.sv | 31 +++
 rtl/iter_shifter.sv | 106 ++++++++++
 tb/tb_iter_shifter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/iter_shifter_if.sv
// Handshake and data bundle for iter_shifter.
//   start  request; the design accepts it only while not busy
//   mode   00 SLL, 01 SRL, 10 SRA, 11 ROL (sampled with start)
//   din    operand (sampled with start)
//   shamt  shift distance 0..WIDTH-1 (sampled with start)
//   busy   high while the shifter is stepping
//   done   one-cycle pulse; dout is valid from this cycle on
//   dout   result register
// The master modport is the requester and the slave modport is the shifter.
interface iter_shifter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  modport master (
    output start, mode, din, shamt,
    input  busy, done, dout
  );

  modport slave (
    input  start, mode, din, shamt,
    output busy, done, dout
  );
endinterface

// File: rtl/iter_shifter.sv
// Multi-cycle shift unit. It does SLL, SRL, SRA or ROL, moving at most STEP bit positions
// per clock, so it needs only a STEP-wide mux and no full barrel shifter.
//   clk    system clock; all state changes on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    iter_shifter_if slave port (start/mode/din/shamt in, busy/done/dout out)
// The accepting edge loads din into dout. Each later edge shifts dout by min(rem, STEP) until
// rem is zero. After that, done pulses for one cycle. The busy and done outputs decode the
// state register directly, so no input reaches an output combinationally.
module iter_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 4
) (
  input logic         clk,
  input logic         rst_n,
  iter_shifter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  // One extra bit, so STEP == WIDTH still fits.
  localparam logic [SHAMT_W:0] STEP_W = (SHAMT_W + 1)'(STEP);

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;

  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   step_k;
  logic [SHAMT_W-1:0] rem_left;
  logic [WIDTH-1:0]   step_res;
  logic               accept;

  assign rem_ext  = {1'b0, rem_q};
  assign step_k   = (rem_ext < STEP_W) ? rem_ext : STEP_W;
  // step_k <= rem_q, so the truncation below never drops a set bit.
  assign rem_left = rem_q - step_k[SHAMT_W-1:0];
  assign accept   = bus.start && (state_q != SHIFT);

  // Each distance 1..STEP is a fixed shift, and step_k picks one of them.
  // step_k == 0 happens only outside SHIFT, and then dout simply holds.
  always_comb begin
    step_res = dout_q;
    for (int unsigned i = 1; i <= STEP; i++) begin
      if (step_k == (SHAMT_W + 1)'(i)) begin
        unique case (mode_q)
          MODE_SLL: step_res = dout_q << i;
          MODE_SRL: step_res = dout_q >> i;
          MODE_SRA: step_res = WIDTH'($signed(dout_q) >>> i);
          MODE_ROL: step_res = (dout_q << i) | (dout_q >> (WIDTH - i));
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    if (accept) begin
      dout_d  = bus.din;
      rem_d   = bus.shamt;
      mode_d  = bus.mode;
      state_d = (bus.shamt != '0) ? SHIFT : DONE;
    end else begin
      case (state_q)
        SHIFT: begin
          dout_d  = step_res;
          rem_d   = rem_left;
          state_d = (rem_left == '0) ? DONE : SHIFT;
        end
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SLL;
      dout_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.dout = dout_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter. It runs three instances: STEP=4, STEP=1 and STEP=32. Each instance
// gets directed and random operations. The bench checks per-cycle busy/done timing and the
// result against a whole-distance arithmetic model.
module tb_iter_shifter;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  start_v = '0;
  logic [1:0]  mode_r = '0;
  logic [31:0] din_r = '0;
  logic [4:0]  shamt_r = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [31:0] dout_v [3];

  int steps [3] = '{4, 1, 32};
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iter_shifter_if #(.WIDTH(W)) if0 ();
  iter_shifter_if #(.WIDTH(W)) if1 ();
  iter_shifter_if #(.WIDTH(W)) if2 ();

  assign if0.start = start_v[0];
  assign if1.start = start_v[1];
  assign if2.start = start_v[2];
  assign if0.mode = mode_r;  assign if0.din = din_r;  assign if0.shamt = shamt_r;
  assign if1.mode = mode_r;  assign if1.din = din_r;  assign if1.shamt = shamt_r;
  assign if2.mode = mode_r;  assign if2.din = din_r;  assign if2.shamt = shamt_r;
  assign busy_v = {if2.busy, if1.busy, if0.busy};
  assign done_v = {if2.done, if1.done, if0.done};
  assign dout_v[0] = if0.dout;
  assign dout_v[1] = if1.dout;
  assign dout_v[2] = if2.dout;

  iter_shifter #(.WIDTH(W), .STEP(4))  dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  iter_shifter #(.WIDTH(W), .STEP(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  iter_shifter #(.WIDTH(W), .STEP(32)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift by the whole distance in one go.
  function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] a, input int s);
    case (m)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return 32'($signed(a) >>> s);
      default: return (s == 0) ? a : ((a << s) | (a >> (32 - s)));
    endcase
  endfunction

  // Starts one operation on instance d and checks every cycle up to done, plus two idle cycles.
  // ign holds start one extra edge with different operands, which lands in SHIFT.
  // chain returns in the done cycle, so the caller can issue the next op there.
  task automatic run_op(input int d, input logic [1:0] m, input logic [31:0] a,
                        input logic [4:0] s, input bit ign, input bit chain);
    logic [31:0] exp;
    int n;
    exp = model(m, a, int'(s));
    n   = (int'(s) + steps[d] - 1) / steps[d];
    mode_r = m; din_r = a; shamt_r = s; start_v[d] = 1'b1;
    @(posedge clk); #1;
    if (ign) begin
      mode_r = ~m; din_r = ~a; shamt_r = s ^ 5'h03;
    end else begin
      start_v[d] = 1'b0;
    end
    for (int j = 0; j <= n + 2; j++) begin
      check($sformatf("d%0d m%0d s%0d j%0d busy", d, m, s, j), {31'b0, busy_v[d]}, {31'b0, j < n});
      check($sformatf("d%0d m%0d s%0d j%0d done", d, m, s, j), {31'b0, done_v[d]}, {31'b0, j == n});
      if (j >= n) check($sformatf("d%0d m%0d s%0d j%0d dout", d, m, s, j), dout_v[d], exp);
      if (j == n && chain) return;
      @(posedge clk); #1;
      start_v[d] = 1'b0;
    end
  endtask

  task automatic reset_mid(input int d);
    mode_r = 2'b00; din_r = $urandom | 32'h1; shamt_r = 5'd20; start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check($sformatf("d%0d rst dout", d), dout_v[d], 32'h0);
    check($sformatf("d%0d rst busy", d), {31'b0, busy_v[d]}, 32'h0);
    check($sformatf("d%0d rst done", d), {31'b0, done_v[d]}, 32'h0);
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      check($sformatf("d%0d post-rst done k%0d", d, k), {31'b0, done_v[d]}, 32'h0);
      check($sformatf("d%0d post-rst busy k%0d", d, k), {31'b0, busy_v[d]}, 32'h0);
    end
    run_op(d, 2'b00, 32'h0000_0101, 5'd20, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset busy", d), {31'b0, busy_v[d]}, 32'h0);
      check($sformatf("d%0d reset done", d), {31'b0, done_v[d]}, 32'h0);
      check($sformatf("d%0d reset dout", d), dout_v[d], 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int d = 0; d < 3; d++) begin
      run_op(d, 2'b00, 32'h0000_0001, 5'd2, 1'b0, 1'b0);
      run_op(d, 2'b00, 32'hC000_0003, 5'd2, 1'b0, 1'b0);
      run_op(d, 2'b10, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
      run_op(d, 2'b01, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
      run_op(d, 2'b11, 32'h8000_0001, 5'd1, 1'b0, 1'b0);
      run_op(d, 2'b11, 32'hF000_0000, 5'd5, 1'b0, 1'b0);
      for (int m = 0; m < 4; m++) run_op(d, 2'(m), 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
      run_op(d, 2'b10, 32'h9234_5678, 5'd9, 1'b1, 1'b0);
      run_op(d, 2'b00, 32'h1234_5678, 5'd3, 1'b1, 1'b0);
      run_op(d, 2'b10, 32'hA5A5_0F0F, 5'd7, 1'b0, 1'b1);
      run_op(d, 2'b11, 32'h0123_4567, 5'd13, 1'b0, 1'b1);
      run_op(d, 2'b01, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b1);
      run_op(d, 2'b01, 32'hFFFF_0000, 5'd17, 1'b0, 1'b0);
      reset_mid(d);
      for (int r = 0; r < 20; r++) begin
        logic [4:0] s;
        bit ign;
        bit chain;
        s     = 5'($urandom_range(0, 31));
        ign   = (s != 5'd0) && ($urandom_range(0, 3) == 0);
        chain = (r != 19) && ($urandom_range(0, 2) == 0);
        run_op(d, 2'($urandom_range(0, 3)), $urandom, s, ign, chain);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
